// File: rtl/decode_instruction.sv
`default_nettype none
// ============================================================================
// Module   : decode_instruction
// Purpose  : Pipeline decode stage with a registered output and a one-entry skid buffer.
// Revision : 1.0
// ============================================================================
module decode_instruction #(
   parameter int WORD = 32,
   parameter int ADDR = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            v_i,
   output logic            stall_o,
   input  logic [WORD-1:0] inst_i,
   input  logic [ADDR-1:0] pc_i,
   input  logic            flush,
   output logic            v_o,
   input  logic            stall_i,
   output logic [ADDR-1:0] pc_o,
   output logic [5:0]      opcode,
   output logic [4:0]      rd,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [WORD-1:0] imm,
   output logic            uses_imm,
   output logic            is_load,
   output logic            is_store,
   output logic            is_branch,
   output logic            is_halt,
   output logic            illegal
);

   localparam logic [5:0] c_OP_LOAD  = 6'h20;
   localparam logic [5:0] c_OP_STORE = 6'h21;
   localparam logic [5:0] c_OP_HALT  = 6'h3F;

   typedef struct packed {
      logic [ADDR-1:0] pc;
      logic [5:0]      opcode;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [WORD-1:0] imm;
      logic            uses_imm;
      logic            is_load;
      logic            is_store;
      logic            is_branch;
      logic            is_halt;
      logic            illegal;
   } dec_t;

   dec_t w_dec;
   dec_t r_out;
   dec_t r_skid;
   logic r_out_valid;
   logic r_skid_valid;
   logic w_accept;
   logic w_alu_reg;
   logic w_alu_imm;

   always_comb begin
      w_dec           = '0;
      w_dec.pc        = pc_i;
      w_dec.opcode    = inst_i[31:26];
      w_dec.rd        = inst_i[25:21];
      w_dec.rs1       = inst_i[20:16];
      w_dec.rs2       = inst_i[15:11];
      w_dec.imm       = {{(WORD-16){inst_i[15]}}, inst_i[15:0]};
      // 0x00 (NOP) shares the ALU-register quadrant but raises no flag
      w_alu_reg       = (inst_i[31:30] == 2'b00);
      w_alu_imm       = (inst_i[31:30] == 2'b01);
      w_dec.is_load   = (inst_i[31:26] == c_OP_LOAD);
      w_dec.is_store  = (inst_i[31:26] == c_OP_STORE);
      w_dec.is_branch = (inst_i[31:28] == 4'b1100);
      w_dec.is_halt   = (inst_i[31:26] == c_OP_HALT);
      w_dec.uses_imm  = w_alu_imm | w_dec.is_load | w_dec.is_store | w_dec.is_branch;
      w_dec.illegal   = ~(w_alu_reg | w_dec.uses_imm | w_dec.is_halt);
   end

   // The skid register being full is exactly the condition that blocks fetch
   assign w_accept = v_i & ~r_skid_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out        <= '0;
         r_skid       <= '0;
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (flush) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (!r_out_valid || !stall_i) begin
         if (r_skid_valid) begin
            r_out        <= r_skid;
            r_out_valid  <= 1'b1;
            r_skid_valid <= 1'b0;
         end else if (w_accept) begin
            r_out       <= w_dec;
            r_out_valid <= 1'b1;
         end else begin
            r_out_valid <= 1'b0;
         end
      end else if (w_accept) begin
         r_skid       <= w_dec;
         r_skid_valid <= 1'b1;
      end
   end

   assign v_o       = r_out_valid;
   assign stall_o   = r_skid_valid;
   assign pc_o      = r_out.pc;
   assign opcode    = r_out.opcode;
   assign rd        = r_out.rd;
   assign rs1       = r_out.rs1;
   assign rs2       = r_out.rs2;
   assign imm       = r_out.imm;
   assign uses_imm  = r_out.uses_imm;
   assign is_load   = r_out.is_load;
   assign is_store  = r_out.is_store;
   assign is_branch = r_out.is_branch;
   assign is_halt   = r_out.is_halt;
   assign illegal   = r_out.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_instruction.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_instruction
// Purpose  : Directed bench for decode_instruction against a two-slot queue model.
// Revision : 1.0
// ============================================================================
module tb_decode_instruction;

   localparam int WORD = 32;
   localparam int ADDR = 16;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            v_i = 1'b0;
   logic            stall_o;
   logic [WORD-1:0] inst_i = '0;
   logic [ADDR-1:0] pc_i = '0;
   logic            flush = 1'b0;
   logic            v_o;
   logic            stall_i = 1'b0;
   logic [ADDR-1:0] pc_o;
   logic [5:0]      opcode;
   logic [4:0]      rd, rs1, rs2;
   logic [WORD-1:0] imm;
   logic            uses_imm, is_load, is_store, is_branch, is_halt, illegal;

   int total = 0;
   int bad = 0;

   decode_instruction #(.WORD(WORD), .ADDR(ADDR)) dut (
      .clk(clk), .reset(reset), .v_i(v_i), .stall_o(stall_o), .inst_i(inst_i),
      .pc_i(pc_i), .flush(flush), .v_o(v_o), .stall_i(stall_i), .pc_o(pc_o),
      .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .uses_imm(uses_imm), .is_load(is_load), .is_store(is_store),
      .is_branch(is_branch), .is_halt(is_halt), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected field vector straight from the opcode class table
   function automatic logic [74:0] expect_fields(input logic [31:0] inst, input logic [15:0] pc);
      int  op;
      logic alu_r, alu_i, ld, st, br, hl, ui, il;
      op    = int'(inst[31:26]);
      alu_r = (op >= 1 && op <= 15);
      alu_i = (op >= 16 && op <= 31);
      ld    = (op == 32);
      st    = (op == 33);
      br    = (op >= 48 && op <= 51);
      hl    = (op == 63);
      ui    = alu_i || ld || st || br;
      il    = !(op == 0 || alu_r || ui || hl);
      return {pc, inst[31:26], inst[25:21], inst[20:16], inst[15:11],
              {{16{inst[15]}}, inst[15:0]}, ui, ld, st, br, hl, il};
   endfunction

   wire [74:0] dut_fields = {pc_o, opcode, rd, rs1, rs2, imm,
                             uses_imm, is_load, is_store, is_branch, is_halt, illegal};

   // Model: the stage holds at most two instructions in acceptance order
   logic [47:0] q[$];
   bit          model_ok = 0;
   bit          zeroed = 0;

   always @(posedge clk) begin
      int  sz;
      bit  acc;
      if (reset) begin
         q.delete();
         zeroed   = 1;
         model_ok = 1;
      end else if (flush) begin
         q.delete();
      end else begin
         sz  = q.size();
         acc = v_i && (sz < 2);
         if (sz > 0 && !stall_i) void'(q.pop_front());
         if (acc) q.push_back({pc_i, inst_i});
         if (q.size() > 0) zeroed = 0;
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         check("v_o", 128'(v_o), 128'(q.size() > 0));
         check("stall_o", 128'(stall_o), 128'(q.size() == 2));
         if (q.size() > 0)
            check("fields", 128'(dut_fields), 128'(expect_fields(q[0][31:0], q[0][47:32])));
         else if (zeroed)
            check("reset_fields", 128'(dut_fields), 128'(0));
      end
   end

   task automatic cyc(input logic r, input logic f, input logic v,
                      input logic [31:0] ins, input logic [15:0] pc, input logic st);
      reset = r; flush = f; v_i = v; inst_i = ins; pc_i = pc; stall_i = st;
      @(negedge clk);
   endtask

   function automatic logic [31:0] alu_rd(input int n);
      logic [31:0] w;
      w = 32'h0400_0000 | (32'(n & 31) << 21) | 32'h0002_1800;
      return w;
   endfunction

   initial begin
      @(negedge clk);
      cyc(1, 0, 0, 0, 0, 0);
      check("rst_v_o", 128'(v_o), 128'(0));
      check("rst_stall_o", 128'(stall_o), 128'(0));
      check("rst_pc_o", 128'(pc_o), 128'(0));

      // Directed decode vectors
      cyc(0, 0, 1, 32'h0422_1800, 16'h0004, 0);
      check("alu_v_o", 128'(v_o), 128'(1));
      check("alu_opcode", 128'(opcode), 128'(6'h01));
      check("alu_regs", 128'({rd, rs1, rs2}), 128'({5'd1, 5'd2, 5'd3}));
      check("alu_uses_imm", 128'(uses_imm), 128'(0));
      check("alu_pc_o", 128'(pc_o), 128'(16'h0004));
      cyc(0, 0, 1, 32'h4020_FFFC, 16'h0005, 0);
      check("alui_imm", 128'(imm), 128'(32'hFFFF_FFFC));
      check("alui_uses_imm", 128'(uses_imm), 128'(1));
      cyc(0, 0, 1, 32'h8022_7FFF, 16'h0006, 0);
      check("ld_imm", 128'(imm), 128'(32'h0000_7FFF));
      check("ld_flag", 128'({is_load, rd, rs1}), 128'({1'b1, 5'd1, 5'd2}));
      cyc(0, 0, 1, 32'h9400_0000, 16'h0007, 0);
      check("illegal_flag", 128'({v_o, illegal}), 128'(2'b11));
      cyc(0, 0, 1, 32'h8400_0000, 16'h0008, 0);
      check("st_flag", 128'({is_store, uses_imm, illegal}), 128'(3'b110));
      cyc(0, 0, 1, 32'hCC00_8000, 16'h0009, 0);
      check("br_flag", 128'({is_branch, imm}), 128'({1'b1, 32'hFFFF_8000}));
      cyc(0, 0, 1, 32'hD000_0000, 16'h000A, 0);
      cyc(0, 0, 1, 32'hFC00_0000, 16'h000B, 0);
      check("halt_flag", 128'({is_halt, illegal}), 128'(2'b10));
      cyc(0, 0, 1, 32'h0000_0000, 16'h000C, 0);
      check("nop_flags", 128'({uses_imm, is_load, is_store, is_branch, is_halt, illegal}), 128'(0));
      cyc(0, 0, 1, 32'hF000_0000, 16'h000D, 0);
      cyc(0, 0, 0, 0, 0, 0);

      // Stall for three cycles starting at pc 1's output
      cyc(0, 0, 1, alu_rd(0), 16'd0, 0);
      cyc(0, 0, 1, alu_rd(1), 16'd1, 0);
      cyc(0, 0, 1, alu_rd(2), 16'd2, 1);
      check("stall_skid", 128'({stall_o, v_o, pc_o}), 128'({1'b1, 1'b1, 16'd1}));
      cyc(0, 0, 1, alu_rd(3), 16'd3, 1);
      cyc(0, 0, 1, alu_rd(3), 16'd3, 1);
      check("stall_hold", 128'(pc_o), 128'(16'd1));
      cyc(0, 0, 1, alu_rd(3), 16'd3, 0);
      check("release", 128'({stall_o, pc_o}), 128'({1'b0, 16'd2}));
      cyc(0, 0, 1, alu_rd(3), 16'd3, 0);
      check("after_rel3", 128'(pc_o), 128'(16'd3));
      cyc(0, 0, 1, alu_rd(4), 16'd4, 0);
      check("after_rel4", 128'(pc_o), 128'(16'd4));
      cyc(0, 0, 0, 0, 0, 0);

      // Flush with both registers full
      cyc(0, 0, 1, alu_rd(16), 16'h0010, 0);
      cyc(0, 0, 1, alu_rd(17), 16'h0011, 1);
      check("pre_flush_full", 128'({v_o, stall_o}), 128'(2'b11));
      cyc(0, 1, 1, alu_rd(18), 16'h0012, 1);
      check("flush", 128'({v_o, stall_o}), 128'(2'b00));
      cyc(0, 0, 1, alu_rd(19), 16'h0013, 0);
      check("post_flush", 128'({v_o, pc_o}), 128'({1'b1, 16'h0013}));
      cyc(0, 0, 0, 0, 0, 0);

      // Reset during a stall with the skid register full
      cyc(0, 0, 1, 32'h4020_FFFC, 16'h0020, 0);
      cyc(0, 0, 1, 32'h8022_7FFF, 16'h0021, 1);
      cyc(1, 0, 1, alu_rd(22), 16'h0022, 1);
      check("mid_reset", 128'({v_o, stall_o, dut_fields}), 128'(0));
      cyc(0, 0, 1, alu_rd(23), 16'h0023, 0);
      check("post_reset", 128'({v_o, pc_o}), 128'({1'b1, 16'h0023}));

      // Sustained streaming across many opcode classes
      for (int i = 0; i < 16; i++) begin
         cyc(0, 0, 1, (32'(i * 4) << 26) | (32'h0123_8765 ^ 32'(i * 32'h1111)), 16'(16'h0100 + i), 0);
         check("stream", 128'({v_o, stall_o, pc_o}), 128'({1'b1, 1'b0, 16'(16'h0100 + i)}));
      end

      // Mixed handshake traffic, checked by the model alone
      for (int i = 0; i < 60; i++) begin
         cyc(0, ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), $urandom,
             16'(16'h0200 + i), 1'($urandom_range(0, 2) == 0));
      end
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
